// File: rtl/prom_fuse_programmer.sv
// rtl/prom_fuse_programmer.sv - single-word programmer for fusible bipolar PROMs
//
// Programs one word per request: pre-read, pulse every bit that must go 0->1
// (lowest bit first), verify after each pulse, retry up to MAX_ATTEMPTS, report.
//
// Ports:
//   clk, reset_n        board clock, async active-low reset
//   start               request, sampled only while idle
//   address_in, data_in target address / word, latched on accepted start
//   chip_data_in        chip readback (valid while chip_select_n is low)
//   chip_address        latched address driven to the chip
//   chip_select_n       chip read enable, active low
//   program_bit_select  one-hot bit line selected for fusing
//   program_pulse       programming-voltage enable
//   busy, done          operation in progress / one-cycle completion strobe
//   error, failed_bits  result of the last operation, held until next start
module prom_fuse_programmer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH   = 9,
  parameter int READ_CYCLES     = 4,
  parameter int SETUP_CYCLES    = 10,
  parameter int PULSE_CYCLES    = 500,
  parameter int RECOVERY_CYCLES = 50,
  parameter int MAX_ATTEMPTS    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic                     chip_select_n,
  output logic [DATA_WIDTH-1:0]    program_bit_select,
  output logic                     program_pulse,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    failed_bits
);

  // Zero-length phases would make the counters wrap; clamp them to one cycle.
  localparam int RD_N  = (READ_CYCLES     < 1) ? 1 : READ_CYCLES;
  localparam int SU_N  = (SETUP_CYCLES    < 1) ? 1 : SETUP_CYCLES;
  localparam int PL_N  = (PULSE_CYCLES    < 1) ? 1 : PULSE_CYCLES;
  localparam int RC_N  = (RECOVERY_CYCLES < 1) ? 1 : RECOVERY_CYCLES;
  localparam int ATT_N = (MAX_ATTEMPTS < 1) ? 1 : ((MAX_ATTEMPTS > 15) ? 15 : MAX_ATTEMPTS);

  localparam int MAX_A = (RD_N > SU_N) ? RD_N : SU_N;
  localparam int MAX_B = (PL_N > RC_N) ? PL_N : RC_N;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RD_LAST = CW'(RD_N - 1);
  localparam logic [CW-1:0] SU_LAST = CW'(SU_N - 1);
  localparam logic [CW-1:0] PL_LAST = CW'(PL_N - 1);
  localparam logic [CW-1:0] RC_LAST = CW'(RC_N - 1);
  localparam logic [3:0]    ATT_MAX = 4'(ATT_N);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE_READ, S_PRE_EVAL, S_SELECT, S_SETUP,
    S_PULSE, S_RECOVER, S_VERIFY, S_VER_EVAL, S_DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [3:0]              attempts;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   read_q;
  logic [DATA_WIDTH-1:0]   pending_q;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic                    pulse_q;

  logic [DATA_WIDTH-1:0]   pending_pre;
  logic [DATA_WIDTH-1:0]   conflict;
  logic [DATA_WIDTH-1:0]   lowest;
  logic [DATA_WIDTH-1:0]   pend_clr;
  logic                    hit;

  assign pending_pre = data_q & ~read_q;
  assign conflict    = ~data_q & read_q;
  // Two's-complement trick isolates the lowest set bit as a one-hot mask.
  assign lowest      = pending_q & (~pending_q + ONE);
  assign pend_clr    = pending_q & ~mask_q;
  assign hit         = |(read_q & mask_q);

  // Gate with reset so the programming voltage is removed the instant reset
  // asserts, independent of the register's reset path.
  assign program_pulse = pulse_q & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cnt                <= '0;
      attempts           <= '0;
      data_q             <= '0;
      read_q             <= '0;
      pending_q          <= '0;
      mask_q             <= '0;
      pulse_q            <= 1'b0;
      chip_address       <= '0;
      chip_select_n      <= 1'b1;
      program_bit_select <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      failed_bits        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            chip_address  <= address_in;
            data_q        <= data_in;
            error         <= 1'b0;
            failed_bits   <= '0;
            busy          <= 1'b1;
            chip_select_n <= 1'b0;
            cnt           <= '0;
            state         <= S_PRE_READ;
          end
        end

        S_PRE_READ: begin
          if (cnt == RD_LAST) begin
            read_q        <= chip_data_in;
            chip_select_n <= 1'b1;
            state         <= S_PRE_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PRE_EVAL: begin
          if (|conflict) begin
            // A fused bit where a blank one is wanted can never be undone.
            failed_bits <= conflict;
            error       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else if (pending_pre == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            pending_q <= pending_pre;
            state     <= S_SELECT;
          end
        end

        S_SELECT: begin
          mask_q             <= lowest;
          program_bit_select <= lowest;
          attempts           <= '0;
          cnt                <= '0;
          state              <= S_SETUP;
        end

        S_SETUP: begin
          if (cnt == SU_LAST) begin
            pulse_q  <= 1'b1;
            attempts <= attempts + 4'd1;
            cnt      <= '0;
            state    <= S_PULSE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PULSE: begin
          if (cnt == PL_LAST) begin
            pulse_q <= 1'b0;
            cnt     <= '0;
            state   <= S_RECOVER;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RECOVER: begin
          if (cnt == RC_LAST) begin
            // Bit select drops on the same edge the read starts, so the two
            // never overlap.
            program_bit_select <= '0;
            chip_select_n      <= 1'b0;
            cnt                <= '0;
            state              <= S_VERIFY;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_VERIFY: begin
          if (cnt == RD_LAST) begin
            read_q        <= chip_data_in;
            chip_select_n <= 1'b1;
            state         <= S_VER_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_VER_EVAL: begin
          if (!hit && (attempts < ATT_MAX)) begin
            program_bit_select <= mask_q;
            cnt                <= '0;
            state              <= S_SETUP;
          end else begin
            if (!hit) begin
              failed_bits <= failed_bits | mask_q;
            end
            pending_q <= pend_clr;
            if (|pend_clr) begin
              state <= S_SELECT;
            end else begin
              error <= (|failed_bits) | ~hit;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prom_fuse_programmer.sv
// tb/tb_prom_fuse_programmer.sv - scoreboard bench for prom_fuse_programmer
module tb_prom_fuse_programmer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] address_in = '0;
  logic [7:0] data_in = '0;
  logic [7:0] chip_data_in;
  logic [8:0] chip_address;
  logic       chip_select_n;
  logic [7:0] program_bit_select;
  logic       program_pulse;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] failed_bits;

  int n_checks = 0;
  int n_fail   = 0;

  prom_fuse_programmer #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(9), .READ_CYCLES(2), .SETUP_CYCLES(2),
    .PULSE_CYCLES(5), .RECOVERY_CYCLES(3), .MAX_ATTEMPTS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .address_in(address_in),
    .data_in(data_in), .chip_data_in(chip_data_in), .chip_address(chip_address),
    .chip_select_n(chip_select_n), .program_bit_select(program_bit_select),
    .program_pulse(program_pulse), .busy(busy), .done(done), .error(error),
    .failed_bits(failed_bits)
  );

  always #5 clk = ~clk;

  // Behavioural PROM: a selected bit fuses when the pulse ends normally.
  logic [7:0] mem [0:511];
  logic [7:0] stuck_mask = 8'h00;
  initial for (int i = 0; i < 512; i++) mem[i] = 8'h00;
  always @(negedge program_pulse)
    if (reset_n) mem[chip_address] = mem[chip_address] | (program_bit_select & ~stuck_mask);
  assign chip_data_in = chip_select_n ? 8'h00 : mem[chip_address];

  typedef struct { logic err; logic [7:0] fb; } done_t;
  done_t      done_q[$];
  logic [7:0] pulse_q[$];
  logic [8:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse-sequence shape, completion results, invariants.
  int         pre = 0, pcnt = 0, post = 0;
  logic       in_seq = 1'b0;
  logic [7:0] seq_sel = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pre = 0; pcnt = 0; post = 0; in_seq = 1'b0;
    end else begin
      if (program_pulse) check("pulse_sel_onehot", 32'($onehot(program_bit_select)), 1);
      if (!chip_select_n) check("read_while_fusing", {program_pulse, program_bit_select}, 0);
      if (busy || done) check("chip_address", chip_address, exp_addr);

      if (program_bit_select != 8'h00) begin
        in_seq = 1'b1;
        if (program_pulse) begin
          pcnt++;
          check("sel_stable_in_pulse", program_bit_select, seq_sel);
        end else if (pcnt == 0) begin
          pre++;
          seq_sel = program_bit_select;
        end else begin
          post++;
        end
      end else if (in_seq) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse_seq", seq_sel, 0);
        end else begin
          logic [7:0] es;
          es = pulse_q.pop_front();
          check("pulse_select", seq_sel, es);
          check("setup_cycles", pre, 2);
          check("pulse_cycles", pcnt, 5);
          check("recovery_cycles", post, 3);
        end
        pre = 0; pcnt = 0; post = 0; in_seq = 1'b0;
      end

      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("error", error, d.err);
          check("failed_bits", failed_bits, d.fb);
          check("busy_in_done", busy, 0);
        end
      end
    end
  end

  task automatic start_op(input logic [8:0] a, input logic [7:0] d, input logic hold);
    @(negedge clk);
    exp_addr   = a;
    address_in = a;
    data_in    = d;
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) found = 1'b1;
    end
    if (!found) check("done_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    logic seen;

    // Reset state
    #12;
    check("rst_pulse", program_pulse, 0);
    check("rst_cs_n", chip_select_n, 1);
    check("rst_sel", program_bit_select, 0);
    check("rst_busy_done_err", {busy, done, error}, 0);
    check("rst_failed", failed_bits, 0);
    check("rst_addr", chip_address, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: blank chip, 0x81 at 0x1A5
    pulse_q.push_back(8'h01);
    pulse_q.push_back(8'h80);
    done_q.push_back('{1'b0, 8'h00});
    start_op(9'h1A5, 8'h81, 1'b0);
    wait_done(cyc);
    check("c1_model_word", mem[9'h1A5], 8'h81);

    // 2: already programmed, done four cycles after accept
    mem[9'h020] = 8'h3C;
    done_q.push_back('{1'b0, 8'h00});
    start_op(9'h020, 8'h3C, 1'b0);
    wait_done(cyc);
    check("c2_done_latency", cyc, 4);

    // 3: conflicting fused bit
    mem[9'h030] = 8'h04;
    done_q.push_back('{1'b1, 8'h04});
    start_op(9'h030, 8'h01, 1'b0);
    wait_done(cyc);
    check("c3_model_word", mem[9'h030], 8'h04);

    // 4: bit 3 never fuses; two attempts then failure
    stuck_mask = 8'h08;
    pulse_q.push_back(8'h08);
    pulse_q.push_back(8'h08);
    done_q.push_back('{1'b1, 8'h08});
    start_op(9'h040, 8'h08, 1'b0);
    wait_done(cyc);
    stuck_mask = 8'h00;
    check("c4_model_word", mem[9'h040], 8'h00);

    // 5: reset in the middle of a pulse
    start_op(9'h050, 8'h02, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (program_pulse) seen = 1'b1;
    end
    check("c5_pulse_seen", seen, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("c5_pulse_drop", program_pulse, 0);
    check("c5_busy", busy, 0);
    check("c5_sel", program_bit_select, 0);
    check("c5_cs_n", chip_select_n, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("c5_model_unfused", mem[9'h050], 8'h00);
    pulse_q.push_back(8'h02);
    done_q.push_back('{1'b0, 8'h00});
    start_op(9'h050, 8'h02, 1'b0);
    wait_done(cyc);
    check("c5_model_word", mem[9'h050], 8'h02);

    // 6: start held through the whole operation, dropped in the cycle after DONE
    pulse_q.push_back(8'h01);
    pulse_q.push_back(8'h80);
    done_q.push_back('{1'b0, 8'h00});
    start_op(9'h060, 8'h81, 1'b1);
    wait_done(cyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    check("c6_no_second_op", seen, 0);
    check("c6_model_word", mem[9'h060], 8'h81);

    repeat (3) @(negedge clk);
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prom_fuse_programmer.md
Name: prom_fuse_programmer

Overview:
- Writer counterpart of the ROM reader: programs one word into a fusible bipolar PROM (IP3604 8-bit / IP3601 4-bit) per request.
- Flow: pre-read the word, pulse each bit that must go 0->1 (LSB first), verify each pulse, retry on failure, report status.
- Sits between the board control logic (buttons/host) and the chip GPIO lines, sharing address/data pins with the reader through the top-level chip mux.

Parameters:
DATA_WIDTH, 8, word width (4 for IP3601).
ADDRESS_WIDTH, 9, address width (8 for IP3601).
READ_CYCLES, 4, cycles chip_select_n is held low per read; data sampled on the last cycle.
SETUP_CYCLES, 10, cycles bit select is held before program_pulse rises.
PULSE_CYCLES, 500, program_pulse high time.
RECOVERY_CYCLES, 50, cycles bit select is held after program_pulse falls.
MAX_ATTEMPTS, 4, maximum pulses per bit (range 1..15).

Ports:
clk  in  1  board clock
reset_n  in  1  async active-low reset
start  in  1  request; sampled only in IDLE
address_in  in  ADDRESS_WIDTH  target address, latched on accepted start
data_in  in  DATA_WIDTH  target word, latched on accepted start
chip_data_in  in  DATA_WIDTH  chip data readback
chip_address  out  ADDRESS_WIDTH  address to chip
chip_select_n  out  1  chip read enable, active low
program_bit_select  out  DATA_WIDTH  one-hot bit-line select for fusing
program_pulse  out  1  programming-voltage enable
busy  out  1  operation in progress
done  out  1  one-cycle completion strobe
error  out  1  last operation failed; held until next accepted start
failed_bits  out  DATA_WIDTH  bits that failed or conflicted in the last operation

Behaviour:
- Convention: blank bit reads 0, fused bit reads 1. A fused bit cannot revert to 0.
- Reset (async assert, sync release): state IDLE. All outputs 0 except chip_select_n=1. program_pulse drops combinationally with reset_n.
- IDLE: start=1 -> latch address_in/data_in; clear error and failed_bits; go to PRE_READ. start in any other state is ignored.
- busy=1 in every state except IDLE and DONE.
- chip_address drives the latched address from PRE_READ through DONE.
- PRE_READ: chip_select_n=0 for exactly READ_CYCLES; sample chip_data_in on the last cycle.
  - pending = data & ~read; conflict = ~data & read.
  - conflict != 0 -> failed_bits=conflict, go to DONE with no pulses.
  - Else pending == 0 -> go to DONE.
  - Else go to SELECT.
- SELECT (1 cycle): pick the lowest set bit of pending; attempt counter=0.
- SETUP: program_bit_select = one-hot of the chosen bit for SETUP_CYCLES; chip_select_n=1.
- PULSE: program_pulse=1 for exactly PULSE_CYCLES; bit select unchanged; attempt counter +1.
- RECOVER: program_pulse=0, bit select held for RECOVERY_CYCLES, then bit select goes to 0.
- VERIFY: read as in PRE_READ.
  - Chosen bit reads 1 -> clear it in pending.
  - Else if attempts < MAX_ATTEMPTS -> back to SETUP.
  - Else set the bit in failed_bits and clear it in pending.
  - Then pending != 0 -> SELECT; else DONE.
- DONE (1 cycle): done=1; error = |failed_bits; next state IDLE.
- Invariants:
  - program_pulse=1 only in PULSE.
  - program_bit_select is zero or one-hot, and never changes while program_pulse=1.
  - chip_select_n=0 never coincides with program_pulse=1 or a nonzero bit select.
- Counters are sized to hold the largest cycle parameter. A parameter value of 0 is treated as 1.

Test Plan:
Bench params: READ=2, SETUP=2, PULSE=5, RECOVERY=3, MAX_ATTEMPTS=2, DATA_WIDTH=8, ADDRESS_WIDTH=9. The bench uses a behavioural PROM model that fuses a bit at the end of a pulse.
1. Blank chip; start with address 0x1A5, data 0x81.
   -> chip_address=0x1A5 throughout.
   -> Two pulse sequences: select 0x01, then 0x80; each program_pulse exactly 5 cycles, preceded by 2 select-only cycles and followed by 3.
   -> done once; error=0; failed_bits=0x00; model word=0x81.
2. Chip already holds 0x3C; data 0x3C.
   -> No program_pulse ever.
   -> done on cycle 4 after start accept (2 read + decision + DONE); error=0.
3. Chip holds 0x04; data 0x01.
   -> No pulses; error=1; failed_bits=0x04.
4. Model bit 3 never fuses; data 0x08.
   -> Exactly 2 pulses with select 0x08; error=1; failed_bits=0x08.
5. Reset mid-PULSE.
   -> program_pulse=0 in the same cycle reset_n falls.
   -> busy=0, select=0x00, chip_select_n=1.
   -> After release, start is accepted normally.
6. start held high for the entire operation of case 1.
   -> Exactly one operation runs; a second operation starts only if start is still high in the cycle after DONE.
